// File: rtl/xbar_pkg.sv
// Shared types and sizing for the 4-port crossbar scheduler.
package xbar_pkg;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned PORT_W    = $clog2(NUM_PORTS);

    typedef logic [PORT_W-1:0]    port_id_t;
    typedef logic [NUM_PORTS-1:0] dst_mask_t;

    // Port visited at position 'offset' of a scan starting at 'base'.
    function automatic port_id_t scan_port(port_id_t base, int unsigned offset);
        return port_id_t'((32'(base) + offset) % NUM_PORTS);
    endfunction

endpackage

// File: rtl/out_channel_ctrl.sv
// One crossbar output: source select register, beat counter, active/last flags.
module out_channel_ctrl
    import xbar_pkg::*;
#(
    parameter int unsigned LEN_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [PORT_W-1:0] src,
    input  logic [LEN_W-1:0]  len,
    output logic              active,
    output logic              last,
    output logic [PORT_W-1:0] sel
);

    logic [LEN_W-1:0] beat_cnt;

    // Final beat once the counter has run down on an active channel.
    assign last = active && (beat_cnt == '0);

    // Load on grant (back-to-back reload on the last beat), else count down and retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            beat_cnt <= '0;
            sel      <= '0;
        end else if (load) begin
            active   <= 1'b1;
            sel      <= src;
            beat_cnt <= (len == '0) ? '0 : len - LEN_W'(1);
        end else if (last) begin
            active   <= 1'b0;
        end else if (active) begin
            beat_cnt <= beat_cnt - LEN_W'(1);
        end
    end

endmodule

// File: rtl/xbar_output_scheduler.sv
// Crossbar scheduler: rotating-priority grant scan with output ownership and starvation reservation.
module xbar_output_scheduler
    import xbar_pkg::*;
#(
    parameter int unsigned LEN_W        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] req_dst,
    input  logic [NUM_PORTS*LEN_W-1:0]    req_len,
    output logic [NUM_PORTS-1:0]          grant,
    output logic [PORT_W-1:0]             common_ptr,
    output logic [NUM_PORTS*PORT_W-1:0]   mux_sel,
    output logic [NUM_PORTS-1:0]          out_active,
    output logic [NUM_PORTS-1:0]          out_last,
    output logic [NUM_PORTS-1:0]          urgent
);

    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    dst_mask_t        dst      [NUM_PORTS];
    logic [LEN_W-1:0] len      [NUM_PORTS];
    logic [WAIT_W-1:0] wait_cnt [NUM_PORTS];
    port_id_t         ld_src   [NUM_PORTS];
    logic [LEN_W-1:0] ld_len   [NUM_PORTS];
    dst_mask_t        out_free;
    dst_mask_t        reserved;
    dst_mask_t        claimed;
    dst_mask_t        load;
    logic             res_valid;
    port_id_t         res_port;
    port_id_t         rp;
    port_id_t         sp;

    // Unpack the flat per-port request buses.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign dst[p] = req_dst[p*NUM_PORTS +: NUM_PORTS];
        assign len[p] = req_len[p*LEN_W +: LEN_W];
    end

    // An output can take a new owner when idle or on its last beat.
    assign out_free = ~out_active | out_last;

    // Urgency once a requester has waited the full starvation limit.
    always_comb begin
        urgent = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            urgent[p] = (wait_cnt[p] == WAIT_W'(STARVE_LIMIT));
        end
    end

    // First urgent port in scan order reserves its destination outputs.
    always_comb begin
        res_valid = 1'b0;
        res_port  = '0;
        reserved  = '0;
        rp        = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            rp = scan_port(common_ptr, i);
            if (!res_valid && urgent[rp]) begin
                res_valid = 1'b1;
                res_port  = rp;
                reserved  = dst[rp];
            end
        end
    end

    // Rotating scan; a request wins only if all its outputs are free and unclaimed.
    always_comb begin
        grant   = '0;
        claimed = '0;
        sp      = '0;
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                sp = scan_port(common_ptr, i);
                if (req[sp] && (dst[sp] != '0) &&
                    ((dst[sp] & ~out_free) == '0) &&
                    ((res_valid && (res_port == sp)) || ((dst[sp] & reserved) == '0)) &&
                    ((dst[sp] & claimed) == '0)) begin
                    grant[sp] = 1'b1;
                    claimed   = claimed | dst[sp];
                end
            end
        end
    end

    // Route each grant to the output channels in its destination mask.
    always_comb begin
        load = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            ld_src[o] = '0;
            ld_len[o] = '0;
        end
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                if (grant[p] && dst[p][o]) begin
                    load[o]   = 1'b1;
                    ld_src[o] = port_id_t'(p);
                    ld_len[o] = len[p];
                end
            end
        end
    end

    // Round-robin pointer and saturating per-port wait counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            common_ptr <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                wait_cnt[p] <= '0;
            end
        end else begin
            common_ptr <= (common_ptr == PORT_W'(NUM_PORTS - 1)) ? '0 : common_ptr + PORT_W'(1);
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (!req[p] || grant[p]) begin
                    wait_cnt[p] <= '0;
                end else if (!urgent[p]) begin
                    wait_cnt[p] <= wait_cnt[p] + WAIT_W'(1);
                end
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        out_channel_ctrl #(
            .LEN_W (LEN_W)
        ) u_out_channel_ctrl (
            .clk    (clk),
            .rst    (rst),
            .load   (load[o]),
            .src    (ld_src[o]),
            .len    (ld_len[o]),
            .active (out_active[o]),
            .last   (out_last[o]),
            .sel    (mux_sel[o*PORT_W +: PORT_W])
        );
    end

endmodule

// File: tb/tb_xbar_output_scheduler.sv
// Scoreboard bench for xbar_output_scheduler: directed requests, queued expectations.
module tb_xbar_output_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_dst;
    logic [15:0] req_len;
    logic [3:0]  grant;
    logic [1:0]  common_ptr;
    logic [7:0]  mux_sel;
    logic [3:0]  out_active;
    logic [3:0]  out_last;
    logic [3:0]  urgent;

    typedef struct packed {
        logic [3:0] act;
        logic [3:0] last;
        logic [7:0] sel;
    } ch_rec_t;

    logic [3:0] exp_grant_q [$];
    ch_rec_t    exp_ch_q    [$];
    logic [1:0] tb_ptr;
    int         n_vec  = 0;
    int         n_miss = 0;
    ch_rec_t    mon_rec;
    logic [3:0] mon_g;

    xbar_output_scheduler #(
        .LEN_W        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_dst    (req_dst),
        .req_len    (req_len),
        .grant      (grant),
        .common_ptr (common_ptr),
        .mux_sel    (mux_sel),
        .out_active (out_active),
        .out_last   (out_last),
        .urgent     (urgent)
    );

    always #5 clk = ~clk;

    // Expected round-robin pointer.
    always @(posedge clk) begin
        if (rst) tb_ptr <= 2'd0;
        else     tb_ptr <= tb_ptr + 2'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic miss(input string name, input logic [31:0] act);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got %0h expected nothing at %0t", name, act, $time);
    endtask

    task automatic push_ch(input logic [3:0] act, input logic [3:0] last, input logic [7:0] sel);
        ch_rec_t r;
        r.act  = act;
        r.last = last;
        r.sel  = sel;
        exp_ch_q.push_back(r);
    endtask

    task automatic set_req(input int p, input logic [3:0] d, input logic [3:0] l);
        req[p]           = 1'b1;
        req_dst[p*4 +: 4] = d;
        req_len[p*4 +: 4] = l;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One cycle; ports that were granted drop their request afterwards.
    task automatic step();
        logic [3:0] g;
        @(negedge clk);
        g = grant;
        cyc();
        req = req & ~g;
    endtask

    task automatic wait_ptr(input logic [1:0] k);
        cyc();
        while (tb_ptr != k) cyc();
    endtask

    // Monitor: pops an expectation whenever the DUT grants or drives an active output.
    always @(negedge clk) begin
        if (!rst) begin
            chk("common_ptr", 32'(common_ptr), 32'(tb_ptr));
            if (out_active != 4'b0000) begin
                if (exp_ch_q.size() == 0) begin
                    miss("out_active_unexpected", 32'(out_active));
                end else begin
                    mon_rec = exp_ch_q.pop_front();
                    chk("out_active", 32'(out_active), 32'(mon_rec.act));
                    chk("out_last", 32'(out_last), 32'(mon_rec.last));
                    for (int o = 0; o < 4; o++) begin
                        if (mon_rec.act[o]) chk("mux_sel", 32'(mux_sel[2*o +: 2]), 32'(mon_rec.sel[2*o +: 2]));
                    end
                end
            end
        end
        if (grant != 4'b0000) begin
            if (exp_grant_q.size() == 0) begin
                miss("grant_unexpected", 32'(grant));
            end else begin
                mon_g = exp_grant_q.pop_front();
                chk("grant", 32'(grant), 32'(mon_g));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        req     = '0;
        req_dst = '0;
        req_len = '0;
        // Request held during reset must not be granted.
        set_req(0, 4'b0001, 4'd1);
        repeat (3) cyc();
        req = '0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_out_active", 32'(out_active), 32'h0);
        chk("rst_out_last", 32'(out_last), 32'h0);
        chk("rst_mux_sel", 32'(mux_sel), 32'h0);
        chk("rst_urgent", 32'(urgent), 32'h0);
        chk("rst_common_ptr", 32'(common_ptr), 32'h0);

        // Unicast P0 -> out1, 3 beats.
        wait_ptr(2'd0);
        set_req(0, 4'b0010, 4'd3);
        exp_grant_q.push_back(4'b0001);
        push_ch(4'b0010, 4'b0000, 8'h00);
        push_ch(4'b0010, 4'b0000, 8'h00);
        push_ch(4'b0010, 4'b0010, 8'h00);
        step();
        repeat (4) cyc();

        // P1 and P3 contend for out0 at ptr=2; P1 wins on P3's last beat.
        wait_ptr(2'd2);
        set_req(1, 4'b0001, 4'd1);
        set_req(3, 4'b0001, 4'd2);
        exp_grant_q.push_back(4'b1000);
        exp_grant_q.push_back(4'b0010);
        push_ch(4'b0001, 4'b0000, 8'h03);
        push_ch(4'b0001, 4'b0001, 8'h03);
        push_ch(4'b0001, 4'b0001, 8'h01);
        repeat (3) step();
        repeat (3) cyc();

        // Disjoint multicast and unicast in the same cycle.
        wait_ptr(2'd1);
        set_req(0, 4'b0110, 4'd2);
        set_req(2, 4'b0001, 4'd1);
        exp_grant_q.push_back(4'b0101);
        push_ch(4'b0111, 4'b0001, 8'h02);
        push_ch(4'b0110, 4'b0110, 8'h00);
        step();
        repeat (3) cyc();

        // Empty mask never granted (goes urgent, reserves nothing); zero length is one beat.
        wait_ptr(2'd3);
        set_req(3, 4'b0000, 4'd5);
        set_req(2, 4'b1000, 4'd0);
        exp_grant_q.push_back(4'b0100);
        push_ch(4'b1000, 4'b1000, 8'h80);
        repeat (10) step();
        set_req(0, 4'b0001, 4'd1);
        exp_grant_q.push_back(4'b0001);
        push_ch(4'b0001, 4'b0001, 8'h00);
        @(negedge clk);
        chk("urgent_empty_mask", 32'(urgent), 32'h8);
        cyc();
        req = '0;
        repeat (3) cyc();

        // Reset in the middle of a 2-output transfer.
        wait_ptr(2'd0);
        set_req(0, 4'b0011, 4'd8);
        exp_grant_q.push_back(4'b0001);
        push_ch(4'b0011, 4'b0000, 8'h00);
        step();
        cyc();
        rst = 1'b1;
        set_req(2, 4'b0100, 4'd1);
        @(negedge clk);
        chk("mid_xfer_active", 32'(out_active), 32'h3);
        cyc();
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        chk("abort_out_active", 32'(out_active), 32'h0);
        chk("abort_out_last", 32'(out_last), 32'h0);
        chk("abort_mux_sel", 32'(mux_sel), 32'h0);
        chk("abort_grant", 32'(grant), 32'h0);
        chk("abort_common_ptr", 32'(common_ptr), 32'h0);

        // Broadcast P1 starved by 2-beat P0 traffic until its reservation kicks in.
        wait_ptr(2'd0);
        set_req(0, 4'b0001, 4'd2);
        set_req(1, 4'b1111, 4'd1);
        repeat (4) exp_grant_q.push_back(4'b0001);
        exp_grant_q.push_back(4'b0010);
        for (int i = 1; i <= 8; i++) begin
            push_ch(4'b0001, (i % 2 == 0) ? 4'b0001 : 4'b0000, 8'h00);
        end
        push_ch(4'b1111, 4'b1111, 8'h55);
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            if (t == 7) chk("urgent_before_limit", 32'(urgent), 32'h0);
            if (t == 8) chk("urgent_at_limit", 32'(urgent), 32'h2);
            cyc();
        end
        req = '0;

        for (int i = 0; i < 20 && (exp_grant_q.size() != 0 || exp_ch_q.size() != 0); i++) cyc();
        repeat (2) cyc();
        if (exp_grant_q.size() != 0) miss("grant_never_seen", 32'(exp_grant_q.size()));
        if (exp_ch_q.size() != 0) miss("channel_never_seen", 32'(exp_ch_q.size()));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
